// File: rtl/karatsuba_seq_mul32.sv
// Sequential 32x32 unsigned Karatsuba multiplier that time-shares one external 16x16 core.
// Optional macro KSM_ZERO_SKIP_EN: zero operands bypass the core and complete in one edge.
module karatsuba_seq_mul32 #(
  parameter int W  = 32,
  parameter int HW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [HW-1:0]  mul_x,
  output logic [HW-1:0]  mul_y,
  input  logic [W-1:0]   mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  typedef enum logic [2:0] {IDLE, MUL_HH, MUL_LL, MUL_MID, COMBINE, DONE} state_t;

  state_t          state_q;
  logic            in_ready_q, out_valid_q;
  logic [HW-1:0]   mul_x_q, mul_y_q;
  logic [HW-1:0]   xl_q, yl_q, sa_q, sb_q;
  logic            ca_q, cb_q;
  logic [W-1:0]    hh_q, ll_q, s_q;
  logic [2*W-1:0]  p_q, p_d;
  logic [HW:0]     sum_a, sum_b;
  logic            skip;

  // Recombination: sa/sb carries are folded back in so the core only ever sees 16-bit operands.
  function automatic logic [2*W-1:0] combine(
    input logic [W-1:0]  hh,
    input logic [W-1:0]  ll,
    input logic [W-1:0]  s,
    input logic [HW-1:0] sa,
    input logic [HW-1:0] sb,
    input logic          ca,
    input logic          cb
  );
    logic [W+2:0] t, mid;
    t = (W+3)'(s)
      + (ca ? ((W+3)'(sb) << HW) : (W+3)'(0))
      + (cb ? ((W+3)'(sa) << HW) : (W+3)'(0))
      + ((W+3)'(ca & cb) << W);
    mid = t - (W+3)'(hh) - (W+3)'(ll);
    return ((2*W)'(hh) << W) + ((2*W)'(mid) << HW) + (2*W)'(ll);
  endfunction

  assign sum_a = {1'b0, x[W-1:HW]} + {1'b0, x[HW-1:0]};
  assign sum_b = {1'b0, y[W-1:HW]} + {1'b0, y[HW-1:0]};
  assign p_d   = combine(hh_q, ll_q, s_q, sa_q, sb_q, ca_q, cb_q);

`ifdef KSM_ZERO_SKIP_EN
  assign skip = (x == '0) || (y == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      xl_q        <= '0;
      yl_q        <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      ca_q        <= 1'b0;
      cb_q        <= 1'b0;
      hh_q        <= '0;
      ll_q        <= '0;
      s_q         <= '0;
      p_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            xl_q       <= x[HW-1:0];
            yl_q       <= y[HW-1:0];
            sa_q       <= sum_a[HW-1:0];
            ca_q       <= sum_a[HW];
            sb_q       <= sum_b[HW-1:0];
            cb_q       <= sum_b[HW];
            if (skip) begin
              p_q         <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              // Core operands are registered one state ahead of the capture.
              mul_x_q <= x[W-1:HW];
              mul_y_q <= y[W-1:HW];
              state_q <= MUL_HH;
            end
          end
        end
        MUL_HH: begin
          hh_q    <= mul_p;
          mul_x_q <= xl_q;
          mul_y_q <= yl_q;
          state_q <= MUL_LL;
        end
        MUL_LL: begin
          ll_q    <= mul_p;
          mul_x_q <= sa_q;
          mul_y_q <= sb_q;
          state_q <= MUL_MID;
        end
        MUL_MID: begin
          s_q     <= mul_p;
          mul_x_q <= '0;
          mul_y_q <= '0;
          state_q <= COMBINE;
        end
        COMBINE: begin
          p_q         <= p_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign p         = p_q;

endmodule

// File: tb/tb_karatsuba_seq_mul32.sv
// Self-checking bench for karatsuba_seq_mul32; the 16x16 core is modelled as a plain multiply.
`timescale 1ns/1ps
module tb_karatsuba_seq_mul32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        in_ready, out_valid;
  logic [15:0] mul_x, mul_y;
  logic [31:0] mul_p;
  logic [63:0] p;

  int total = 0;
  int bad = 0;
  logic [15:0] cx [4];
  logic [15:0] cy [4];

  karatsuba_seq_mul32 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  assign mul_p = 32'(mul_x) * 32'(mul_y);

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef KSM_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    return 4;
  endfunction

  // Issues one operand pair and waits for out_valid; leaves the result pending.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                        output logic [63:0] res, output int lat, output bit ok);
    ok = 0; lat = 0; res = '0;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1; x = a; y = b;
    @(posedge clk); #1;
    in_valid = hold; x = $urandom; y = $urandom;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) begin cx[i] = mul_x; cy[i] = mul_y; end
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin ok = 1; break; end
    end
    res = p;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 64'd0 || mul_x !== 16'd0 || mul_y !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b p=%h mul_x=%h mul_y=%h, want 1 0 0 0 0",
               in_ready, out_valid, p, mul_x, mul_y);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] xa [3] = '{32'hFFFF_FFFF, 32'h8000_8000, 32'h0000_FFFF};
    logic [31:0] ya [3] = '{32'hFFFF_FFFF, 32'h8000_8000, 32'hFFFF_0000};
    logic [63:0] want [3] = '{64'hFFFF_FFFE_0000_0001, 64'h4000_8000_4000_0000, 64'h0000_FFFE_0001_0000};
    logic [63:0] res; int lat; bit ok;
    for (int i = 0; i < 3; i++) begin
      run_op(xa[i], ya[i], 1'b0, res, lat, ok);
      total++;
      if (!ok || res !== want[i] || lat != 4) begin
        bad++;
        $display("FAIL directed_%0d: p=%h lat=%0d valid_seen=%0d, want p=%h lat=4", i, res, lat, ok, want[i]);
      end
      if (i == 2) begin
        total++;
        if (cx[0] !== 16'h0000 || cy[0] !== 16'hFFFF || cx[1] !== 16'hFFFF || cy[1] !== 16'h0000 ||
            cx[2] !== 16'hFFFF || cy[2] !== 16'hFFFF || cx[3] !== 16'h0000 || cy[3] !== 16'h0000) begin
          bad++;
          $display("FAIL core_sequence: got (%h,%h) (%h,%h) (%h,%h) (%h,%h), want (0000,ffff) (ffff,0000) (ffff,ffff) (0000,0000)",
                   cx[0], cy[0], cx[1], cy[1], cx[2], cy[2], cx[3], cy[3]);
        end
      end
      ack();
    end
  endtask

  task automatic test_reset_midop();
    bit seen = 0;
    in_valid = 1'b1; x = 32'd5; y = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== 64'd0) begin
      bad++;
      $display("FAIL reset_midop: out_valid=%b in_ready=%b p=%h, want 0 1 0", out_valid, in_ready, p);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_no_result: out_valid seen=%0d, want 0", seen);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res, want; int lat; bit ok; int errs = 0;
    logic [31:0] a, b;
    a = $urandom; b = $urandom; want = ref_mul(a, b);
    run_op(a, b, 1'b0, res, lat, ok);
    total++;
    if (!ok || res !== want) begin
      bad++;
      $display("FAIL bp_result: p=%h valid_seen=%0d, want %h", res, ok, want);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (p !== want || out_valid !== 1'b1 || in_ready !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bp_hold: %0d cycles unstable (last p=%h out_valid=%b in_ready=%b), want 0", errs, p, out_valid, in_ready);
    end
    ack();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero();
    logic [63:0] res; int lat; bit ok;
    run_op(32'h0, 32'h1234, 1'b0, res, lat, ok);
    total++;
    if (!ok || res !== 64'd0 || lat != exp_lat(32'h0, 32'h1234) || cx[0] !== 16'd0 || cy[0] !== 16'd0) begin
      bad++;
      $display("FAIL zero_operand: p=%h lat=%0d core=(%h,%h), want p=0 lat=%0d core=(0,0)",
               res, lat, cx[0], cy[0], exp_lat(32'h0, 32'h1234));
    end
    ack();
  endtask

  task automatic test_random();
    logic [63:0] res; int lat; bit ok; logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = '0;
        1: b = 32'hFFFF_FFFF;
        2: a = {$urandom_range(0, 1) ? 16'hFFFF : 16'h8000, 16'hFFFF};
        default: ;
      endcase
      run_op(a, b, 1'b0, res, lat, ok);
      total++;
      if (!ok || res !== ref_mul(a, b) || lat != exp_lat(a, b)) begin
        bad++;
        $display("FAIL random_%0d: x=%h y=%h p=%h lat=%0d, want p=%h lat=%0d", i, a, b, res, lat, ref_mul(a, b), exp_lat(a, b));
      end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int lat; bit ok; logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      run_op(a, b, 1'b1, res, lat, ok);
      total++;
      if (!ok || res !== ref_mul(a, b) || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_%0d: p=%h in_ready=%b, want p=%h in_ready=0", i, res, in_ready, ref_mul(a, b));
      end
      ack();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL b2b_ready_%0d: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midop();
    test_backpressure();
    test_zero();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
